cmd_queue: RTL and testbench
============================

# cmd_queue

Command buffer and dispatch scheduler between the UART wrapper and the command processor. Accepts 16-bit command words from the UART wrapper into a DEPTH-entry FIFO. Issues them one at a time to the command processor and holds each issued word stable until that command completes. Sends an 8-bit acknowledge (0xA5) or timeout error (0xEE) through the UART transmitter per command, and aborts commands that exceed a cycle budget.

## Interface
Parameters:
- DEPTH, 4 — FIFO entries; power of 2, ≥2
- TMO_W, 26 — timeout counter width
- TMO_CYC, 50_000_000 — cycles allowed in BUSY before abort; 1 ≤ TMO_CYC < 2^TMO_W

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high; one clock, synchronous active-high reset
- in_cmd  in  16  command word from UART wrapper
- in_cmd_rdy  in  1  UART wrapper holds a valid word
- in_clr_cmd_rdy  out  1  word accepted; combinational
- cmd  out  16  registered command word to command processor
- cmd_rdy  out  1  command available to command processor
- clr_cmd_rdy  in  1  command processor has taken cmd
- send_resp  in  1  command processor finished the current command
- tx_start  out  1  one-cycle pulse to start a UART transmit
- tx_data  out  8  response byte
- tx_done  in  1  UART transmit complete
- abort  out  1  one-cycle pulse on timeout
- flush  in  1  clear queued (not in-flight) entries
- q_cnt  out  $clog2(DEPTH)+1  entries currently queued
- full  out  1  q_cnt == DEPTH
- empty  out  1  q_cnt == 0
- tmo_err  out  1  sticky; set on any timeout, cleared only by rst

## Operation
- Reset values: cmd=16'h0000, cmd_rdy=0, tx_start=0, tx_data=8'h00, abort=0, q_cnt=0, full=0, empty=1, tmo_err=0, state=IDLE, pointers=0, timeout count=0.
- Push:
  - in_clr_cmd_rdy = in_cmd_rdy & ~full & ~flush.
  - When it is high, in_cmd is written at the clock edge.
  - If full, the word stays pending in the UART wrapper (back-pressure only; nothing is dropped).
- Pop: occurs only on the IDLE→ISSUE transition. The head word is loaded into cmd in that same edge.
- Push and pop in the same cycle: both take effect and q_cnt is unchanged. Push eligibility uses `full` from the start of the cycle.
- Pointers wrap modulo DEPTH.
- flush:
  - Sets both pointers equal and q_cnt to 0 in one cycle.
  - Does not affect state, cmd, the timeout count, or the response in progress.
  - A push or pop in the same cycle is suppressed.
- FSM states:
  - IDLE: if ~empty → ISSUE (pop, load cmd).
  - ISSUE: cmd_rdy=1; on clr_cmd_rdy → BUSY and clear the timeout count.
  - BUSY:
    - send_resp → RESP with tx_data=8'hA5.
    - Otherwise, when count == TMO_CYC-1 → RESP with tx_data=8'hEE, abort=1 for one cycle, tmo_err set.
    - Otherwise count increments.
  - RESP: tx_start=1 only in the first RESP cycle; tx_data held. On tx_done → IDLE.
- cmd holds its value from load until the next pop, including through BUSY and RESP. The command processor reads cmd[1:0] during a move.
- send_resp and timeout expiry in the same cycle: send_resp wins (0xA5, no abort, tmo_err unchanged).
- send_resp or clr_cmd_rdy outside BUSY or ISSUE respectively: ignored.
- tx_done outside RESP: ignored.
- rst mid-operation: every register returns to its reset value in that edge. Queued and in-flight commands are discarded and no response is sent.

## Timing
- Push into an empty queue:
  - Word written at edge E0.
  - IDLE sees ~empty and pops at E1.
  - cmd and cmd_rdy are valid after E1 (2-cycle latency).
- cmd_rdy is a registered state decode and deasserts the cycle after clr_cmd_rdy is sampled.
- send_resp sampled at edge Ek → tx_start high for the cycle after Ek.
- Timeout: abort and tx_start assert together, exactly TMO_CYC cycles after entering BUSY.
- tx_done sampled in RESP → IDLE next cycle. If the queue is non-empty, the next pop occurs one edge later: tx_done to the next cmd_rdy is 2 cycles.
- Throughput: at most one command in flight. Minimum 4 cycles per command, plus processor and UART time.

## Test plan
- Reset, then push 16'h2155 (heading) into the empty queue → cmd=16'h2155 and cmd_rdy=1 two cycles later. Drive clr_cmd_rdy → cmd_rdy=0 next cycle, cmd still 16'h2155. Drive send_resp → tx_start pulse, tx_data=8'hA5. Drive tx_done → IDLE, empty=1.
- Push 5 words with DEPTH=4 and the first not yet dispatched → full=1 at q_cnt=4, in_clr_cmd_rdy=0 for the 5th. After one dispatch the 5th is accepted. Dispatch order equals push order across pointer wrap.
- TMO_CYC=8, no send_resp → abort, tx_start and tx_data=8'hEE exactly 8 cycles after BUSY entry; tmo_err=1 and stays 1 through later successful commands.
- TMO_CYC=8, send_resp on the expiry cycle → tx_data=8'hA5, abort=0, tmo_err=0.
- Three queued words with one in BUSY, then flush → q_cnt=0 next cycle. The in-flight command still completes with 0xA5 and no further cmd_rdy occurs. Simultaneous push during flush is not accepted (in_clr_cmd_rdy=0).
- Assert rst while in RESP with 2 queued → all outputs at reset values next cycle, and no tx_start occurs afterward until a new push.

Source files
------------

// File: rtl/cmd_queue_if.sv
// Bundle of the command-buffer handshakes: UART wrapper push side,
// command processor issue side, UART transmit side, plus status.
// The master modport is the environment around the queue; slave is the queue.
interface cmd_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [15:0]   in_cmd;
  logic          in_cmd_rdy;
  logic          in_clr_cmd_rdy;
  logic [15:0]   cmd;
  logic          cmd_rdy;
  logic          clr_cmd_rdy;
  logic          send_resp;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_done;
  logic          abort;
  logic          flush;
  logic [CW-1:0] q_cnt;
  logic          full;
  logic          empty;
  logic          tmo_err;
  logic [1:0]    dbg_state;

  modport master (
    output in_cmd, in_cmd_rdy, clr_cmd_rdy, send_resp, tx_done, flush,
    input  in_clr_cmd_rdy, cmd, cmd_rdy, tx_start, tx_data, abort,
           q_cnt, full, empty, tmo_err, dbg_state
  );

  modport slave (
    input  in_cmd, in_cmd_rdy, clr_cmd_rdy, send_resp, tx_done, flush,
    output in_clr_cmd_rdy, cmd, cmd_rdy, tx_start, tx_data, abort,
           q_cnt, full, empty, tmo_err, dbg_state
  );
endinterface

// File: rtl/cmd_queue.sv
// Command buffer and dispatch scheduler: DEPTH-entry FIFO of 16-bit command
// words, one command in flight at a time, 0xA5 ack / 0xEE timeout response.
//
// Handshakes (all sampled at posedge clk):
//   push : a word transfers when in_cmd_rdy && in_clr_cmd_rdy; the wrapper
//          keeps in_cmd_rdy/in_cmd stable until it sees in_clr_cmd_rdy.
//   issue: cmd is valid while cmd_rdy; the processor acknowledges with
//          clr_cmd_rdy, after which cmd_rdy drops but cmd stays stable.
//   done : send_resp ends the command (only while BUSY); tx_done ends the
//          response (only while RESP). Out-of-state pulses are ignored.
module cmd_queue #(
  parameter int DEPTH   = 4,
  parameter int TMO_W   = 26,
  parameter int TMO_CYC = 50_000_000
) (
  input logic        clk,
  input logic        rst,
  cmd_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]    CNT_FULL = CW'(DEPTH);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);
  localparam logic [7:0]       RESP_ACK = 8'hA5;
  localparam logic [7:0]       RESP_TMO = 8'hEE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [15:0]      r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_cnt;
  logic [15:0]      r_cmd;
  logic [7:0]       r_tx_data;
  logic             r_tx_start;
  logic             r_abort;
  logic             r_tmo_err;
  logic [TMO_W-1:0] r_tmo_cnt;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_tmo_clr;
  logic             w_tmo_inc;
  logic             w_resp_go;
  logic             w_abort_go;
  logic [7:0]       w_resp_byte;

  assign w_full  = (r_cnt == CNT_FULL);
  assign w_empty = (r_cnt == '0);
  // Push eligibility uses the registered full flag, so a same-cycle pop
  // never opens a slot early; flush blocks pushes outright.
  assign w_push  = bus.in_cmd_rdy & ~w_full & ~bus.flush;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state and per-transition control strobes.
  always_comb begin
    w_next      = r_state;
    w_pop       = 1'b0;
    w_tmo_clr   = 1'b0;
    w_tmo_inc   = 1'b0;
    w_resp_go   = 1'b0;
    w_abort_go  = 1'b0;
    w_resp_byte = RESP_ACK;
    case (r_state)
      IDLE: begin
        if (!w_empty && !bus.flush) begin
          w_next = ISSUE;
          w_pop  = 1'b1;
        end
      end
      ISSUE: begin
        if (bus.clr_cmd_rdy) begin
          w_next    = BUSY;
          w_tmo_clr = 1'b1;
        end
      end
      BUSY: begin
        // A completion arriving on the expiry cycle wins over the timeout.
        if (bus.send_resp) begin
          w_next      = RESP;
          w_resp_go   = 1'b1;
          w_resp_byte = RESP_ACK;
        end else if (r_tmo_cnt == TMO_LAST) begin
          w_next      = RESP;
          w_resp_go   = 1'b1;
          w_abort_go  = 1'b1;
          w_resp_byte = RESP_TMO;
        end else begin
          w_tmo_inc = 1'b1;
        end
      end
      RESP: begin
        if (bus.tx_done) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.in_cmd;
  end

  // FIFO pointers and occupancy; flush empties the queue without touching
  // the command already issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else if (bus.flush) begin
      r_wr_ptr <= r_rd_ptr;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Issued command word, response byte/pulses, timeout counter, sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd      <= 16'h0000;
      r_tx_data  <= 8'h00;
      r_tx_start <= 1'b0;
      r_abort    <= 1'b0;
      r_tmo_err  <= 1'b0;
      r_tmo_cnt  <= '0;
    end else begin
      if (w_pop)      r_cmd     <= r_mem[r_rd_ptr];
      if (w_resp_go)  r_tx_data <= w_resp_byte;
      if (w_abort_go) r_tmo_err <= 1'b1;
      r_tx_start <= w_resp_go;
      r_abort    <= w_abort_go;
      if (w_tmo_clr)      r_tmo_cnt <= '0;
      else if (w_tmo_inc) r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  assign bus.in_clr_cmd_rdy = w_push;
  assign bus.cmd            = r_cmd;
  assign bus.cmd_rdy        = (r_state == ISSUE);
  assign bus.tx_start       = r_tx_start;
  assign bus.tx_data        = r_tx_data;
  assign bus.abort          = r_abort;
  assign bus.q_cnt          = r_cnt;
  assign bus.full           = w_full;
  assign bus.empty          = w_empty;
  assign bus.tmo_err        = r_tmo_err;
  assign bus.dbg_state      = r_state;
endmodule

// File: tb/tb_cmd_queue.sv
// Bench for cmd_queue: directed scenarios followed by randomized per-cycle
// stimulus, with a negedge monitor comparing against a queue-based model.
module tb_cmd_queue;
  localparam int DEPTH   = 4;
  localparam int TMO_W   = 8;
  localparam int TMO_CYC = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  cmd_queue_if #(.DEPTH(DEPTH)) bus();

  cmd_queue #(
    .DEPTH  (DEPTH),
    .TMO_W  (TMO_W),
    .TMO_CYC(TMO_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  logic [15:0] exp_q[$];       // words accepted and not yet dispatched
  logic [8:0]  exp_resp_q[$];  // {abort, byte} responses awaiting tx_start

  bit          m_issue, m_busy, m_resp, m_inflight, m_tmo;
  int          m_busy_start;
  logic [15:0] m_cur = 16'h0000;
  logic [7:0]  m_tx  = 8'h00;
  bit          prev_rdy;

  // Effects recorded at one negedge, applied at the next (the edge between).
  bit          p_rst = 1'b1;
  bit          p_push, p_flush, p_pop, p_clr, p_send, p_done;
  logic [15:0] p_word;

  always @(negedge clk) begin : monitor
    bit         exp_start;
    logic [8:0] r;
    exp_start = 1'b0;
    if (p_rst) begin
      exp_q.delete();
      exp_resp_q.delete();
      m_issue = 0; m_busy = 0; m_resp = 0; m_inflight = 0; m_tmo = 0;
      m_cur = 16'h0000;
      m_tx  = 8'h00;
    end else begin
      if (p_done) begin
        m_resp     = 0;
        m_inflight = 0;
      end
      if (m_busy && (p_send || cyc == m_busy_start + TMO_CYC)) begin
        exp_resp_q.push_back(p_send ? {1'b0, 8'hA5} : {1'b1, 8'hEE});
        if (!p_send) m_tmo = 1;
        m_busy    = 0;
        m_resp    = 1;
        exp_start = 1'b1;
      end
      if (p_clr) begin
        m_issue      = 0;
        m_busy       = 1;
        m_busy_start = cyc;
      end
      if (bus.cmd_rdy && !prev_rdy) begin
        chk("dispatch_has_entry", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) m_cur = exp_q.pop_front();
      end
      if (p_flush) exp_q.delete();
      else begin
        if (p_pop) begin
          m_issue    = 1;
          m_inflight = 1;
        end
        if (p_push) exp_q.push_back(p_word);
      end
    end

    chk("cmd_rdy", bus.cmd_rdy, m_issue);
    chk("cmd", bus.cmd, m_cur);
    chk("tx_start", bus.tx_start, exp_start);
    if (bus.tx_start && exp_resp_q.size() != 0) begin
      r    = exp_resp_q.pop_front();
      m_tx = r[7:0];
      chk("resp_tx_data", bus.tx_data, r[7:0]);
      chk("resp_abort", bus.abort, r[8]);
    end else begin
      chk("abort_quiet", bus.abort, 0);
    end
    chk("tx_data_hold", bus.tx_data, m_tx);
    chk("q_cnt", bus.q_cnt, exp_q.size());
    chk("full", bus.full, exp_q.size() == DEPTH);
    chk("empty", bus.empty, exp_q.size() == 0);
    chk("tmo_err", bus.tmo_err, m_tmo);
    chk("in_clr_cmd_rdy", bus.in_clr_cmd_rdy,
        bus.in_cmd_rdy && exp_q.size() < DEPTH && !bus.flush);

    p_rst    = rst;
    p_push   = bus.in_cmd_rdy && exp_q.size() < DEPTH && !bus.flush;
    p_word   = bus.in_cmd;
    p_flush  = bus.flush;
    p_pop    = !m_inflight && exp_q.size() != 0 && !bus.flush;
    p_clr    = bus.clr_cmd_rdy && m_issue;
    p_send   = bus.send_resp && m_busy;
    p_done   = bus.tx_done && m_resp;
    prev_rdy = bus.cmd_rdy;
  end

  // ---------------- driver tasks ----------------
  // One cycle: inputs change 1 time unit after posedge; a pending push is
  // dropped once the queue has taken it.
  task automatic tick();
    bit acc;
    @(negedge clk);
    acc = bus.in_cmd_rdy && bus.in_clr_cmd_rdy;
    @(posedge clk);
    #1;
    if (acc) bus.in_cmd_rdy = 1'b0;
  endtask

  task automatic push_word(logic [15:0] w);
    bus.in_cmd     = w;
    bus.in_cmd_rdy = 1'b1;
    for (int i = 0; i < 60 && bus.in_cmd_rdy; i++) tick();
    chk("push_accepted", bus.in_cmd_rdy, 0);
  endtask

  task automatic wait_rdy(string name);
    for (int i = 0; i < 60 && !bus.cmd_rdy; i++) tick();
    chk(name, bus.cmd_rdy, 1);
  endtask

  task automatic wait_tx(string name, output logic [7:0] d, output logic ab);
    for (int i = 0; i < 60 && !bus.tx_start; i++) tick();
    chk(name, bus.tx_start, 1);
    d  = bus.tx_data;
    ab = bus.abort;
  endtask

  task automatic pulse_clr(output int eb);
    bus.clr_cmd_rdy = 1'b1;
    eb = cyc + 1;
    tick();
    bus.clr_cmd_rdy = 1'b0;
  endtask

  task automatic pulse_send();
    bus.send_resp = 1'b1;
    tick();
    bus.send_resp = 1'b0;
  endtask

  task automatic pulse_done();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic run_ok(logic [15:0] w);
    logic [7:0] d;
    logic       ab;
    int         eb;
    push_word(w);
    wait_rdy("run_rdy");
    chk("run_cmd", bus.cmd, w);
    pulse_clr(eb);
    pulse_send();
    wait_tx("run_tx", d, ab);
    chk("run_ack", d, 8'hA5);
    pulse_done();
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [7:0]  d;
    logic        ab;
    int          eb;
    bit          seen;
    logic [15:0] words [5];

    bus.in_cmd = 16'h0000; bus.in_cmd_rdy = 0; bus.clr_cmd_rdy = 0;
    bus.send_resp = 0; bus.tx_done = 0; bus.flush = 0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_empty", bus.empty, 1);
    chk("reset_cmd_rdy", bus.cmd_rdy, 0);

    // Heading command: 2-cycle issue latency, hold through completion.
    push_word(16'h2155);
    chk("t1_not_yet", bus.cmd_rdy, 0);
    tick();
    chk("t1_rdy", bus.cmd_rdy, 1);
    chk("t1_cmd", bus.cmd, 16'h2155);
    pulse_clr(eb);
    chk("t1_rdy_drop", bus.cmd_rdy, 0);
    chk("t1_cmd_hold", bus.cmd, 16'h2155);
    repeat (3) tick();
    pulse_send();
    wait_tx("t1_tx", d, ab);
    chk("t1_ack", d, 8'hA5);
    pulse_done();
    chk("t1_empty", bus.empty, 1);

    // send_resp lands exactly on the expiry cycle: completion wins.
    push_word(16'h1111);
    wait_rdy("t4_rdy");
    pulse_clr(eb);
    while (cyc < eb + TMO_CYC - 1) tick();
    pulse_send();
    wait_tx("t4_tx", d, ab);
    chk("t4_ack", d, 8'hA5);
    chk("t4_no_abort", ab, 0);
    chk("t4_tmo_err", bus.tmo_err, 0);
    pulse_done();

    // No completion: abort + 0xEE exactly TMO_CYC cycles into BUSY.
    push_word(16'h2222);
    wait_rdy("t3_rdy");
    pulse_clr(eb);
    wait_tx("t3_tx", d, ab);
    chk("t3_err_byte", d, 8'hEE);
    chk("t3_abort", ab, 1);
    chk("t3_latency", cyc - eb, TMO_CYC);
    chk("t3_tmo_err", bus.tmo_err, 1);
    pulse_done();
    run_ok(16'h3333);
    chk("t3_tmo_sticky", bus.tmo_err, 1);

    // Back-pressure at full, then ordered drain across pointer wrap.
    words[0] = 16'hA001; words[1] = 16'hA002; words[2] = 16'hA003;
    words[3] = 16'hA004; words[4] = 16'hA005;
    push_word(16'hA000);
    wait_rdy("t2_rdy0");
    for (int i = 0; i < 4; i++) push_word(words[i]);
    chk("t2_full", bus.full, 1);
    chk("t2_q_cnt", bus.q_cnt, 4);
    bus.in_cmd = words[4];
    bus.in_cmd_rdy = 1'b1;
    tick();
    chk("t2_blocked", bus.in_clr_cmd_rdy, 0);
    chk("t2_pending", bus.in_cmd_rdy, 1);
    pulse_clr(eb);
    pulse_send();
    wait_tx("t2_tx0", d, ab);
    pulse_done();
    for (int i = 0; i < 20 && bus.in_cmd_rdy; i++) tick();
    chk("t2_fifth_taken", bus.in_cmd_rdy, 0);
    for (int i = 0; i < 5; i++) begin
      wait_rdy("t2_rdy");
      chk("t2_order", bus.cmd, words[i]);
      pulse_clr(eb);
      pulse_send();
      wait_tx("t2_tx", d, ab);
      pulse_done();
    end

    // Flush with one in flight and three queued; push during flush refused.
    push_word(16'hB000);
    wait_rdy("t5_rdy");
    pulse_clr(eb);
    push_word(16'hB001);
    push_word(16'hB002);
    push_word(16'hB003);
    chk("t5_q3", bus.q_cnt, 3);
    bus.in_cmd = 16'hB004;
    bus.in_cmd_rdy = 1'b1;
    bus.flush = 1'b1;
    #1;
    chk("t5_flush_block", bus.in_clr_cmd_rdy, 0);
    tick();
    bus.flush = 1'b0;
    bus.in_cmd_rdy = 1'b0;
    chk("t5_q0", bus.q_cnt, 0);
    chk("t5_cmd_hold", bus.cmd, 16'hB000);
    pulse_send();
    wait_tx("t5_tx", d, ab);
    chk("t5_ack", d, 8'hA5);
    pulse_done();
    seen = 0;
    repeat (10) begin
      tick();
      seen |= bus.cmd_rdy;
    end
    chk("t5_no_issue", seen, 0);

    // Reset during RESP with two queued words.
    push_word(16'hC000);
    wait_rdy("t6_rdy");
    pulse_clr(eb);
    push_word(16'hC001);
    push_word(16'hC002);
    pulse_send();
    wait_tx("t6_tx", d, ab);
    chk("t6_q2", bus.q_cnt, 2);
    do_reset();
    chk("t6_cmd", bus.cmd, 16'h0000);
    chk("t6_q0", bus.q_cnt, 0);
    chk("t6_tx_data", bus.tx_data, 8'h00);
    chk("t6_tmo_err", bus.tmo_err, 0);
    seen = 0;
    repeat (10) begin
      tick();
      seen |= bus.tx_start | bus.cmd_rdy;
    end
    chk("t6_silent", seen, 0);

    // Randomized traffic, including out-of-state pulses and a mid-run reset.
    for (int i = 0; i < 3000; i++) begin
      if (!bus.in_cmd_rdy && $urandom_range(0, 3) == 0) begin
        bus.in_cmd     = 16'($urandom);
        bus.in_cmd_rdy = 1'b1;
      end
      bus.clr_cmd_rdy = ($urandom_range(0, 2) == 0);
      bus.send_resp   = ($urandom_range(0, 11) == 0);
      bus.tx_done     = ($urandom_range(0, 3) == 0);
      bus.flush       = ($urandom_range(0, 60) == 0);
      rst             = (i == 1500);
      tick();
    end
    rst = 1'b0;
    bus.in_cmd_rdy = 0; bus.clr_cmd_rdy = 0; bus.send_resp = 0;
    bus.tx_done = 0; bus.flush = 0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
